// File: rtl/omsp_spm_cmd_seq_pkg.sv
// Shared encodings for the Sancus protection command path: operation codes,
// query selector codes and the fixed result words returned to the execution unit.
package omsp_spm_cmd_seq_pkg;

  typedef enum logic [1:0] {
    SPM_OP_PROTECT   = 2'd0,
    SPM_OP_UNPROTECT = 2'd1,
    SPM_OP_QUERY     = 2'd2,
    SPM_OP_ILLEGAL   = 2'd3
  } spm_op_e;

  // data_request selector codes; zero means no request is active
  localparam logic [1:0]  SPM_REQ_NONE = 2'd0;

  localparam logic [15:0] SPM_RES_OK   = 16'h0001;
  localparam logic [15:0] SPM_RES_ZERO = 16'h0000;

  // Protect and unprotect both go through the single-cycle update strobe
  function automatic logic op_is_update(input logic [1:0] op);
    return (op == SPM_OP_PROTECT) || (op == SPM_OP_UNPROTECT);
  endfunction

endpackage

// File: rtl/omsp_spm_cmd_seq.sv
// Sancus command sequencer: accepts one protect/unprotect/query command,
// drives the SPM control strobes, and returns a 16-bit result plus error flag.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_IDLE   | ready for a command (cmd_ready=1)
//  S_UPDATE | single update_spm cycle; violation sampled at its closing edge
//  S_QUERY  | data_request held; wait counter runs down to zero
//  S_DONE   | result_valid held until result_ready
module omsp_spm_cmd_seq
  import omsp_spm_cmd_seq_pkg::*;
#(
  parameter int QUERY_WAIT = 1
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_sel,
  output logic        cmd_ready,
  input  logic        violation,
  input  logic        spm_select_valid,
  input  logic [15:0] requested_data,
  output logic        update_spm,
  output logic        enable_spm,
  output logic [1:0]  data_request,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [15:0] result_data,
  output logic        result_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_QUERY  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(QUERY_WAIT - 1);

  state_e     state;
  spm_op_e    op_q;
  logic [3:0] wait_cnt;

  // Sequencer FSM; every output is registered so strobes never see cmd_* combinationally
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state        <= S_IDLE;
      op_q         <= SPM_OP_PROTECT;
      wait_cnt     <= 4'd0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      update_spm   <= 1'b0;
      enable_spm   <= 1'b0;
      data_request <= SPM_REQ_NONE;
      result_valid <= 1'b0;
      result_data  <= SPM_RES_ZERO;
      result_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= spm_op_e'(cmd_op);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (op_is_update(cmd_op)) begin
              state      <= S_UPDATE;
              update_spm <= 1'b1;
              enable_spm <= (cmd_op == SPM_OP_PROTECT);
            end else if ((cmd_op == SPM_OP_QUERY) && (cmd_sel != SPM_REQ_NONE)) begin
              state        <= S_QUERY;
              wait_cnt     <= WAIT_LOAD;
              data_request <= cmd_sel;
            end else begin
              // illegal op or empty selector: fail without touching SPM control
              state        <= S_DONE;
              result_valid <= 1'b1;
              result_data  <= SPM_RES_ZERO;
              result_err   <= 1'b1;
            end
          end
        end

        S_UPDATE: begin
          state        <= S_DONE;
          update_spm   <= 1'b0;
          enable_spm   <= 1'b0;
          result_valid <= 1'b1;
          // SPM control never checks on disable, so unprotect ignores violation
          if ((op_q == SPM_OP_PROTECT) && violation) begin
            result_data <= SPM_RES_ZERO;
            result_err  <= 1'b1;
          end else begin
            result_data <= SPM_RES_OK;
            result_err  <= 1'b0;
          end
        end

        S_QUERY: begin
          if (wait_cnt == 4'd0) begin
            state        <= S_DONE;
            data_request <= SPM_REQ_NONE;
            result_valid <= 1'b1;
            if (spm_select_valid) begin
              result_data <= requested_data;
              result_err  <= 1'b0;
            end else begin
              result_data <= SPM_RES_ZERO;
              result_err  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_DONE: begin
          if (result_ready) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
